// File: rtl/fish_pkg.sv
// Shared types and constants for the fishing game sequencer.
package fish_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FISH = 3'd1,
        REEL = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } phase_t;

    localparam int REEL_MAX        = 16383;
    localparam int SCORE_MAX       = 65535;
    localparam int SCORE_PER_LEVEL = 100;
    localparam int NUM_LEVELS_DEF  = 4;

endpackage

// File: rtl/fish_round_sequencer_sec_countdown.sv
// Per-level seconds countdown driven by the frame-rate enable.
module sec_countdown
    import fish_pkg::*;
#(
    parameter int TICKS_PER_SEC = 60,
    parameter int LEVEL_TIME    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    input  logic       frame_tick,
    output logic [7:0] time_left,
    output logic       expire
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;
    logic          wrap;

    assign wrap   = run && frame_tick && (prescaler == PS_LAST);
    // Combinational so the caller changes state on the same edge time_left hits 0
    assign expire = wrap && (time_left == 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            time_left <= '0;
        end else if (load) begin
            prescaler <= '0;
            time_left <= 8'(LEVEL_TIME);
        end else if (run && frame_tick) begin
            if (wrap) begin
                prescaler <= '0;
                if (time_left != 8'd0)
                    time_left <= time_left - 8'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fish_round_sequencer.sv
// Game-level sequencer: level, score, reel credits and level timer.
module fish_round_sequencer
    import fish_pkg::*;
#(
    parameter int TICKS_PER_SEC = 60,
    parameter int LEVEL_TIME    = 30,
    parameter int REEL_STEP     = 40,
    parameter int NUM_LEVELS    = NUM_LEVELS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        reel_btn,
    input  logic        hooked,
    input  logic        landed,
    output logic [13:0] reel,
    output logic [2:0]  level,
    output logic [7:0]  time_left,
    output logic [15:0] score,
    output logic [2:0]  phase,
    output logic        game_over,
    output logic        win
);

    phase_t      state, state_n;
    logic [2:0]  level_n;
    logic [15:0] score_n;
    logic [13:0] reel_n;
    logic        start_q, reel_q;
    logic        start_edge, reel_edge;
    logic        load, run, expire;
    logic [15:0] reel_sum;
    logic [13:0] reel_upd;
    logic [9:0]  lvl_pts;
    logic [16:0] score_sum;
    logic [15:0] score_upd;

    assign start_edge = start && !start_q;
    assign reel_edge  = reel_btn && !reel_q;

    // A landing freezes the timer so the credited time is not decremented
    assign run = ((state == FISH) || (state == REEL))
               && !((state == REEL) && landed);

    sec_countdown #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .LEVEL_TIME   (LEVEL_TIME)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .run       (run),
        .frame_tick(frame_tick),
        .time_left (time_left),
        .expire    (expire)
    );

    always_comb begin
        reel_sum = {2'b00, reel}
                 + (reel_edge ? 16'(REEL_STEP) : 16'd0)
                 - ((frame_tick && reel != 14'd0) ? 16'd1 : 16'd0);
        reel_upd = (reel_sum > 16'(REEL_MAX)) ? 14'(REEL_MAX)
                                              : reel_sum[13:0];
        lvl_pts   = 10'(level) * 10'(SCORE_PER_LEVEL);
        score_sum = {1'b0, score} + 17'(lvl_pts) + 17'(time_left);
        score_upd = (score_sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX)
                                                 : score_sum[15:0];
    end

    always_comb begin
        state_n = state;
        level_n = level;
        score_n = score;
        reel_n  = reel;
        load    = 1'b0;
        if (start_edge) begin
            state_n = FISH;
            level_n = 3'd1;
            score_n = '0;
            reel_n  = '0;
            load    = 1'b1;
        end else begin
            case (state)
                FISH: begin
                    reel_n = '0;
                    if (expire)
                        state_n = LOSE;
                    else if (hooked)
                        state_n = REEL;
                end
                REEL: begin
                    if (landed) begin
                        reel_n  = '0;
                        score_n = score_upd;
                        if (level == 3'(NUM_LEVELS)) begin
                            state_n = WIN;
                        end else begin
                            state_n = FISH;
                            level_n = level + 3'd1;
                            load    = 1'b1;
                        end
                    end else if (expire) begin
                        state_n = LOSE;
                        reel_n  = '0;
                    end else begin
                        reel_n = reel_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            level   <= '0;
            score   <= '0;
            reel    <= '0;
            start_q <= 1'b0;
            reel_q  <= 1'b0;
        end else begin
            state   <= state_n;
            level   <= level_n;
            score   <= score_n;
            reel    <= reel_n;
            start_q <= start;
            reel_q  <= reel_btn;
        end
    end

    assign phase     = state;
    assign game_over = (state == WIN) || (state == LOSE);
    assign win       = (state == WIN);

endmodule

// File: tb/tb_fish_round_sequencer.sv
// Directed self-checking bench for fish_round_sequencer.
module tb_fish_round_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        reel_btn = 1'b0;
    logic        hooked = 1'b0;
    logic        landed = 1'b0;
    logic [13:0] reel;
    logic [2:0]  level;
    logic [7:0]  time_left;
    logic [15:0] score;
    logic [2:0]  phase;
    logic        game_over;
    logic        win;

    int total = 0;
    int bad   = 0;
    int exp_score;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_FISH = 3'd1;
    localparam logic [2:0] P_REEL = 3'd2;
    localparam logic [2:0] P_WIN  = 3'd3;
    localparam logic [2:0] P_LOSE = 3'd4;

    fish_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .start     (start),
        .reel_btn  (reel_btn),
        .hooked    (hooked),
        .landed    (landed),
        .reel      (reel),
        .level     (level),
        .time_left (time_left),
        .score     (score),
        .phase     (phase),
        .game_over (game_over),
        .win       (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic press();
        reel_btn = 1'b1;
        cyc();
        reel_btn = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) cyc();
        frame_tick = 1'b0;
    endtask

    task automatic hook();
        hooked = 1'b1;
        cyc();
        hooked = 1'b0;
    endtask

    task automatic land();
        landed = 1'b1;
        cyc();
        landed = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_phase", 32'(phase), 32'(P_IDLE));
        chk("rst_level", 32'(level), 0);
        chk("rst_score", 32'(score), 0);
        rst = 1'b0;
        cyc();

        // Timeout without hook
        do_start();
        chk("start_phase", 32'(phase), 32'(P_FISH));
        chk("start_time", 32'(time_left), 30);
        chk("start_level", 32'(level), 1);
        ticks(1799);
        chk("pre_exp_time", 32'(time_left), 1);
        chk("pre_exp_phase", 32'(phase), 32'(P_FISH));
        ticks(1);
        chk("exp_time", 32'(time_left), 0);
        chk("exp_phase", 32'(phase), 32'(P_LOSE));
        chk("exp_over", 32'(game_over), 1);
        chk("exp_win", 32'(win), 0);

        // Reel presses and first catch
        do_start();
        chk("restart_phase", 32'(phase), 32'(P_FISH));
        press();
        chk("fish_ignore_btn", 32'(reel), 0);
        hook();
        chk("hook_phase", 32'(phase), 32'(P_REEL));
        press(); press(); press();
        chk("reel_120", 32'(reel), 120);
        ticks(10);
        chk("reel_110", 32'(reel), 110);
        ticks(290);
        chk("tl_25", 32'(time_left), 25);
        land();
        chk("l1_score", 32'(score), 125);
        chk("l1_level", 32'(level), 2);
        chk("l1_reel", 32'(reel), 0);
        chk("l1_phase", 32'(phase), 32'(P_FISH));
        chk("l1_time", 32'(time_left), 30);

        // Full four-level win
        do_start();
        chk("win_run_score0", 32'(score), 0);
        exp_score = 0;
        for (int l = 1; l <= 4; l++) begin
            hook();
            ticks(600);
            chk("lvl_tl20", 32'(time_left), 20);
            land();
            exp_score += 100 * l + 20;
            chk("lvl_score", 32'(score), 32'(exp_score));
        end
        chk("win_total", 32'(score), 1080);
        chk("win_phase", 32'(phase), 32'(P_WIN));
        chk("win_flag", 32'(win), 1);
        chk("win_over", 32'(game_over), 1);
        chk("win_level", 32'(level), 4);
        ticks(100);
        chk("win_frozen", 32'(time_left), 20);
        do_start();
        chk("after_win_phase", 32'(phase), 32'(P_FISH));
        chk("after_win_score", 32'(score), 0);
        chk("after_win_level", 32'(level), 1);

        // Edge plus tick at zero, then saturation
        hook();
        reel_btn = 1'b1;
        frame_tick = 1'b1;
        cyc();
        reel_btn = 1'b0;
        frame_tick = 1'b0;
        cyc();
        chk("edge_tick_zero", 32'(reel), 40);
        repeat (409) press();
        chk("sat_first", 32'(reel), 16383);
        ticks(13);
        chk("reel_16370", 32'(reel), 16370);
        press();
        chk("sat_16383", 32'(reel), 16383);
        press();
        chk("sat_hold", 32'(reel), 16383);

        // Landing on the expiry tick counts as a catch
        ticks(1785);
        chk("tl_1", 32'(time_left), 1);
        chk("reel_before_land", 32'(reel), 14598);
        hook();
        chk("hook_in_reel_phase", 32'(phase), 32'(P_REEL));
        chk("hook_in_reel_reel", 32'(reel), 14598);
        landed = 1'b1;
        frame_tick = 1'b1;
        cyc();
        landed = 1'b0;
        frame_tick = 1'b0;
        chk("tie_score", 32'(score), 101);
        chk("tie_phase", 32'(phase), 32'(P_FISH));
        chk("tie_level", 32'(level), 2);
        chk("tie_time", 32'(time_left), 30);

        // Asynchronous reset mid-REEL
        hook();
        repeat (13) press();
        ticks(20);
        chk("reel_500", 32'(reel), 500);
        rst = 1'b1;
        #2;
        chk("arst_reel", 32'(reel), 0);
        chk("arst_phase", 32'(phase), 32'(P_IDLE));
        chk("arst_level", 32'(level), 0);
        chk("arst_score", 32'(score), 0);
        chk("arst_time", 32'(time_left), 0);
        chk("arst_over", 32'(game_over), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_phase", 32'(phase), 32'(P_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
